rx_data_capture: RTL
====================

Name: rx_data_capture

Overview:
- Receive datapath and status stage directly downstream of the Rx engine control.
- Consumes the control's BTU, DONE and start strobes and samples RX on each mid-bit BTU into a 10-bit shift register.
- On DONE, right-justifies the frame, extracts the data byte, checks parity and stop bit, and holds the byte plus status flags for the host.
- Host clears status through a read strobe.

Parameters:
RDATA_RST, 8'h00, reset/initial value of the data output register

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
RX  input  1  synchronized serial receive line
BTU  input  1  bit-time-up strobe from Rx engine control, 1 clk wide
DONE  input  1  frame-complete strobe from Rx engine control, 1 clk wide
start  input  1  high while control is in start-bit (half bit time) phase
EIGHT  input  1  1 = 8 data bits, 0 = 7
PEN  input  1  parity enable
OHEL  input  1  parity sense: 1 = odd, 0 = even
read_clr  input  1  host read strobe, clears status
rdata  output  8  received byte (7-bit mode: bit 7 = 0)
RXRDY  output  1  byte available
PERR  output  1  parity error on held byte
FERR  output  1  framing error (stop bit = 0)
OVF  output  1  overrun: new byte captured while RXRDY still set
BRK  output  1  break detected (optional feature, else 0)

Behaviour:
- Reset (rst = 0 at a clk edge), including mid-frame:
  - sr[9:0] = 10'h3FF (idle line).
  - rdata = RDATA_RST.
  - RXRDY, PERR, FERR, OVF and BRK = 0.
- Shift: on BTU = 1 and start = 0 and DONE = 0, sr <= {RX, sr[9:1]} (LSB first; newest bit enters sr[9]). BTU while start = 1 is the start-bit check and does not shift.
- Bits shifted per frame N = 7 + EIGHT + PEN + 1 (stop), giving 8, 9, 9 or 10.
- Capture on the DONE cycle, combinational from sr:
  - j = sr >> (10 − N).
  - stop = sr[9].
  - data = EIGHT ? j[7:0] : {1'b0, j[6:0]}.
  - rxpar = EIGHT ? j[8] : j[7].
  - calc = (^data) ^ OHEL.
- Registered on the DONE edge; outputs valid the cycle after DONE (1-cycle latency):
  - rdata <= data.
  - PERR <= PEN & (calc != rxpar).
  - FERR <= ~stop.
  - OVF <= RXRDY & ~read_clr.
  - RXRDY <= 1.
- DONE coincident with BTU: DONE has priority. Capture uses the current sr and the shift is discarded (control never issues both; bench asserts they never coincide).
- read_clr without DONE: next cycle RXRDY, PERR, FERR, OVF and BRK = 0. rdata holds.
- read_clr and DONE in the same cycle: capture wins. RXRDY = 1, flags take the new frame's values, OVF = 0.
- OVF is sticky across further DONEs: it is set again if RXRDY = 1, and is never cleared except by read_clr or reset.
- EIGHT, PEN and OHEL are sampled only at DONE. Changing them mid-frame is undefined for that frame only.
- No state machine beyond sr and the flags. Frame sequencing is owned by the upstream control.

Optional Feature:
- Macro: RX_BREAK_DETECT_EN.
- Defined: at DONE, BRK <= (j[N−1:0] == 0), i.e. all data, parity and stop bits are zero. BRK is cleared by read_clr or reset. FERR is still set in this case.
- Undefined: BRK is tied to 0 and no compare logic is built.

Test Plan:
- 8E1 (EIGHT=1, PEN=1, OHEL=0): send 0xA5, parity 0, stop 1 -> rdata=8'hA5, RXRDY=1, PERR=0, FERR=0 one clk after DONE.
- Same frame with parity bit 1 -> rdata=8'hA5, PERR=1. With OHEL=1 and parity 1 -> PERR=0.
- 7N1 (EIGHT=0, PEN=0): send 0x41 -> rdata=8'h41, PERR=0. Stop bit driven 0 -> FERR=1.
- Two 8N1 frames 0x12 then 0x34 without read_clr -> rdata=8'h34, OVF=1. read_clr -> RXRDY=OVF=PERR=FERR=0, rdata stays 8'h34. read_clr pulsed on the second DONE cycle instead -> OVF=0, RXRDY=1.
- rst=0 asserted after 4 BTUs of a frame -> next clk all flags 0, rdata=8'h00. A following clean frame 0x5A captures correctly.
- With RX_BREAK_DETECT_EN: 8P1 with all bits 0 -> BRK=1, FERR=1. Without the macro -> BRK=0.

Source files
------------

// File: rtl/rx_data_capture.sv
// rx_data_capture: receive datapath and status stage behind the Rx engine control.
// Samples RX into a 10-bit shift register on each mid-bit BTU.
// On DONE it latches the data byte plus the parity and framing flags.
// The host clears the status flags with read_clr.
// Optional build macro: RX_BREAK_DETECT_EN. When it is defined, BRK flags a frame
// whose bits are all zero. When it is undefined, BRK is tied to 0.
module rx_data_capture #(
  parameter logic [7:0] RDATA_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       BTU,
  input  logic       DONE,
  input  logic       start,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  input  logic       read_clr,
  output logic [7:0] rdata,
  output logic       RXRDY,
  output logic       PERR,
  output logic       FERR,
  output logic       OVF,
  output logic       BRK
);

  localparam int unsigned SR_W = 10;
  localparam int unsigned J_W  = 9;

  logic [SR_W-1:0] sr;
  logic [1:0]      shamt_c;
  logic [J_W-1:0]  j_c;
  logic [7:0]      data_c;
  logic            rxpar_c;
  logic            calc_c;
  logic            stop_c;

  // Right-justify the last N shifted bits and decode the data, parity and stop bits.
  // The shift amount is 10 - N, which reduces to 2 - EIGHT - PEN.
  // Bit 9 of the justified frame is only ever the stop bit, so it is read from sr[9].
  always_comb begin
    shamt_c = 2'd2 - 2'(EIGHT) - 2'(PEN);
    j_c     = J_W'(sr >> shamt_c);
    stop_c  = sr[9];
    data_c  = EIGHT ? j_c[7:0] : {1'b0, j_c[6:0]};
    rxpar_c = EIGHT ? j_c[8] : j_c[7];
    calc_c  = (^data_c) ^ OHEL;
  end

  // Serial shift register. It is LSB first, and the newest bit enters at the top.
  // DONE has priority over BTU, and the start-bit check does not shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= {SR_W{1'b1}};
    end else if (BTU && !start && !DONE) begin
      sr <= {RX, sr[SR_W-1:1]};
    end
  end

  // Capture the frame on DONE, or clear the status flags on a host read.
  // Capture wins when both happen in the same cycle.
  // OVF stays set until read_clr or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= RDATA_RST;
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end else if (DONE) begin
      rdata <= data_c;
      PERR  <= PEN & (calc_c != rxpar_c);
      FERR  <= ~stop_c;
      OVF   <= ~read_clr & (OVF | RXRDY);
      RXRDY <= 1'b1;
    end else if (read_clr) begin
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end
  end

`ifdef RX_BREAK_DETECT_EN
  logic brk_c;

  // A break is a frame in which the data, parity and stop bits are all zero.
  assign brk_c = (j_c == J_W'(0)) & ~stop_c;

  // The break flag is captured with the frame and cleared by a host read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      BRK <= 1'b0;
    end else if (DONE) begin
      BRK <= brk_c;
    end else if (read_clr) begin
      BRK <= 1'b0;
    end
  end
`else
  assign BRK = 1'b0;
`endif

endmodule
